bcd_time_loader: RTL and testbench
==================================

// Module: bcd_time_loader
// PURPOSE
//  Reverse path of the stopwatch digit splitter: assembles six BCD digits (mm:ss:cc,
//  tens first) entered one at a time from the keypad/button front end into binary
//  minute/second/msecond bytes for the time counters. Validates every digit,
//  commits all three fields atomically with a one-cycle load strobe, flags bad entries.
// PARAMETERS
//  MIN_TENS_MAX    5        largest legal minute tens digit
//  SEC_TENS_MAX    5        largest legal second tens digit
//  MS_TENS_MAX     9        largest legal msecond (1/100 s) tens digit
//  TIMEOUT_CYCLES  1000000  idle cycles before a partial entry is aborted (macro only)
//  TW              20       timeout counter width; 2**TW > TIMEOUT_CYCLES
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous reset, active-high
//  digit_valid  in   1  digit present on digit
//  digit        in   4  BCD digit
//  digit_ready  out  1  block can accept a digit
//  clear        in   1  abandon current entry
//  minute       out  8  committed minutes, binary 0..(MIN_TENS_MAX*10+9)
//  second       out  8  committed seconds, binary
//  msecond      out  8  committed hundredths, binary
//  load         out  1  one-cycle strobe: minute/second/msecond just updated
//  busy         out  1  partial entry in progress or load cycle
//  err          out  1  one-cycle strobe: entry rejected/aborted
//  digit_idx    out  3  index of next expected digit, 0..5
// BEHAVIOUR
//  - Reset: minute=second=msecond=0, load=0, err=0, busy=0, digit_idx=0,
//    staging cleared, FSM in D0; digit_ready=1 after reset deasserts.
//  - FSM: D0(min tens) D1(min ones) D2(sec tens) D3(sec ones) D4(ms tens)
//    D5(ms ones) LOAD. digit_idx = state index in D0..D5, 0 in LOAD.
//  - Digit accepted on a clk edge with digit_valid & digit_ready. digit_ready=1 in
//    D0..D5, 0 in LOAD. No acceptance without digit_valid; state holds.
//  - Tens states store digit; ones states write staging field = tens*10+ones
//    (8-bit, computed as (t<<3)+(t<<1)+o; max 99, no overflow).
//  - Validity: any digit>9 invalid; tens digit > its *_TENS_MAX invalid.
//    Invalid accepted digit -> err=1 next cycle, FSM to D0, staging discarded,
//    committed outputs unchanged.
//  - Accepting D5 moves to LOAD; in LOAD, minute/second/msecond take staged
//    values on the same edge load rises (latency: load high 1 cycle after the
//    6th digit is accepted). LOAD -> D0 unconditionally after one cycle.
//  - Outputs hold their committed values until the next load; never partial.
//  - busy = (state in D1..D5) | (state==LOAD).
//  - clear: highest priority except rst. In D0..D5, digit in same cycle discarded,
//    FSM to D0, staging discarded, no err. In LOAD, commit still completes; clear
//    ignored. clear in D0 is a no-op.
//  - rst mid-entry: immediate return to reset state, committed values zeroed.
//  - err and load never high in the same cycle.
// CONFIGURATION
//  - DIGIT_TIMEOUT_EN defined: TW-bit idle counter, zeroed on every accepted digit
//    and whenever state is D0 or LOAD; increments each cycle in D1..D5. When it
//    reaches TIMEOUT_CYCLES-1: err=1 next cycle, FSM to D0, staging discarded.
//    clear or an accepted digit in that cycle takes priority over the timeout.
//  - DIGIT_TIMEOUT_EN undefined: no counter; a partial entry waits indefinitely.
// TESTING
//  - Digits 1,2,3,4,5,6 back-to-back -> load 1 cycle after 6th; minute=12,
//    second=34, msecond=56; digit_idx 0..5 then 0; busy low after load.
//  - Digits 5,9,5,9,9,9 -> minute=59, second=59, msecond=99; then 0,0,0,0,0,0 -> all 0.
//  - Digit 6 at D0 -> err pulse, digit_idx=0, outputs unchanged; digit 0xA at D3 ->
//    err pulse, back to D0, no load.
//  - 1,2,3 then clear with digit_valid=1 -> no err, digit_idx=0; then 0,0,0,0,9,9
//    -> minute=0, second=0, msecond=99.
//  - Commit 12:34:56, enter 4,4 then assert rst -> all outputs 0, digit_idx=0.
//  - With DIGIT_TIMEOUT_EN, TIMEOUT_CYCLES=16: enter 1,2 then idle 16 cycles ->
//    err pulse, digit_idx=0; without macro, idle 1000 cycles -> digit_idx stays 2.

Source files
------------

// File: rtl/bcd_time_loader.sv
// Assembles six keypad BCD digits (mm:ss:cc, tens first) into binary time fields and
// commits them atomically with a one-cycle load strobe. Optional macro: DIGIT_TIMEOUT_EN.
module bcd_time_loader #(
  parameter int MIN_TENS_MAX   = 5,
  parameter int SEC_TENS_MAX   = 5,
  parameter int MS_TENS_MAX    = 9,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TW             = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic       digit_ready,
  input  logic       clear,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [7:0] msecond,
  output logic       load,
  output logic       busy,
  output logic       err,
  output logic [2:0] digit_idx
);

  typedef enum logic [2:0] {D0, D1, D2, D3, D4, D5, LOAD} state_t;

  localparam logic [3:0] MIN_TMAX = 4'(MIN_TENS_MAX);
  localparam logic [3:0] SEC_TMAX = 4'(SEC_TENS_MAX);
  localparam logic [3:0] MS_TMAX  = 4'(MS_TENS_MAX);

  // A timeout that cannot be reached by the idle counter is a configuration error.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (1 << TW)) begin : g_bad_timeout
    $error("bcd_time_loader: TIMEOUT_CYCLES must satisfy 2 <= TIMEOUT_CYCLES < 2**TW");
  end

  state_t     state_reg;
  logic [3:0] tens_reg;
  logic [7:0] min_stage_reg;
  logic [7:0] sec_stage_reg;
  logic [7:0] ms_stage_reg;

  logic       accept;
  logic       bad_digit;
  logic       timeout_hit;
  logic [7:0] tens8;
  logic [7:0] field_value;

  assign digit_ready = (state_reg != LOAD);
  assign accept      = digit_valid && digit_ready && !clear;
  assign busy        = (state_reg != D0);
  assign digit_idx   = (state_reg == LOAD) ? 3'd0 : 3'(state_reg);

  // tens*10 + ones without a multiplier
  assign tens8       = {4'd0, tens_reg};
  assign field_value = (tens8 << 3) + (tens8 << 1) + {4'd0, digit};

  always_comb begin
    bad_digit = (digit > 4'd9);
    case (state_reg)
      D0:      if (digit > MIN_TMAX) bad_digit = 1'b1;
      D2:      if (digit > SEC_TMAX) bad_digit = 1'b1;
      D4:      if (digit > MS_TMAX)  bad_digit = 1'b1;
      default: ;
    endcase
  end

`ifdef DIGIT_TIMEOUT_EN
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_reg <= '0;
    end else if (state_reg == D0 || state_reg == LOAD || accept) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + TW'(1);
    end
  end

  assign timeout_hit = (state_reg != D0) && (state_reg != LOAD) && (idle_cnt_reg == IDLE_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= D0;
      tens_reg      <= '0;
      min_stage_reg <= '0;
      sec_stage_reg <= '0;
      ms_stage_reg  <= '0;
      minute        <= '0;
      second        <= '0;
      msecond       <= '0;
      load          <= 1'b0;
      err           <= 1'b0;
    end else begin
      load <= 1'b0;
      err  <= 1'b0;
      if (state_reg == LOAD) begin
        // Commit is never interrupted, not even by clear.
        minute    <= min_stage_reg;
        second    <= sec_stage_reg;
        msecond   <= ms_stage_reg;
        load      <= 1'b1;
        state_reg <= D0;
      end else if (clear || (accept && bad_digit) || (!accept && timeout_hit)) begin
        err           <= !clear;
        state_reg     <= D0;
        tens_reg      <= '0;
        min_stage_reg <= '0;
        sec_stage_reg <= '0;
        ms_stage_reg  <= '0;
      end else if (accept) begin
        case (state_reg)
          D0: begin tens_reg <= digit; state_reg <= D1; end
          D1: begin min_stage_reg <= field_value; state_reg <= D2; end
          D2: begin tens_reg <= digit; state_reg <= D3; end
          D3: begin sec_stage_reg <= field_value; state_reg <= D4; end
          D4: begin tens_reg <= digit; state_reg <= D5; end
          D5: begin ms_stage_reg <= field_value; state_reg <= LOAD; end
          default: state_reg <= D0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_loader.sv
// Self-checking bench for bcd_time_loader: directed entries plus randomized traffic
// checked every cycle against a digit-list model of the entry rules.
module tb_bcd_time_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_ready;
  logic       clear = 1'b0;
  logic [7:0] minute, second, msecond;
  logic       load, busy, err;
  logic [2:0] digit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: digits entered so far (pos = 6 means a full entry awaiting commit).
  int pos = 0;
  int dig[6];
  int exp_min = 0, exp_sec = 0, exp_ms = 0;
  int exp_load = 0, exp_err = 0;

  bcd_time_loader #(
    .MIN_TENS_MAX(5), .SEC_TENS_MAX(5), .MS_TENS_MAX(9),
    .TIMEOUT_CYCLES(16), .TW(20)
  ) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .digit_ready(digit_ready), .clear(clear), .minute(minute), .second(second),
    .msecond(msecond), .load(load), .busy(busy), .err(err), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic bit legal(input int p, input int d);
    if (d > 9) return 0;
    if (p == 0 && d > 5) return 0;
    if (p == 2 && d > 5) return 0;
    return 1;
  endfunction

  task automatic check_all();
    chk("load", int'(load), exp_load);
    chk("err", int'(err), exp_err);
    chk("minute", int'(minute), exp_min);
    chk("second", int'(second), exp_sec);
    chk("msecond", int'(msecond), exp_ms);
    chk("digit_idx", int'(digit_idx), (pos == 6) ? 0 : pos);
    chk("busy", int'(busy), (pos != 0) ? 1 : 0);
    chk("digit_ready", int'(digit_ready), (pos != 6) ? 1 : 0);
  endtask

  // One clock cycle with the given inputs; model advances, then DUT is checked.
  task automatic cycle(input logic v, input logic [3:0] d, input logic c);
    digit_valid = v;
    digit       = d;
    clear       = c;
    exp_load = 0;
    exp_err  = 0;
    if (pos == 6) begin
      exp_min  = dig[0] * 10 + dig[1];
      exp_sec  = dig[2] * 10 + dig[3];
      exp_ms   = dig[4] * 10 + dig[5];
      exp_load = 1;
      pos      = 0;
    end else if (c) begin
      pos = 0;
    end else if (v) begin
      if (!legal(pos, int'(d))) begin
        exp_err = 1;
        pos     = 0;
      end else begin
        dig[pos] = int'(d);
        pos++;
      end
    end
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    clear       = 1'b0;
    check_all();
    $display("t=%0t v=%0b d=%0d clr=%0b -> idx=%0d load=%0b err=%0b time=%0d:%0d:%0d",
             $time, v, d, c, digit_idx, load, err, minute, second, msecond);
  endtask

  task automatic entry(input int a, input int b, input int c2, input int d, input int e, input int f);
    cycle(1'b1, 4'(a), 1'b0);
    cycle(1'b1, 4'(b), 1'b0);
    cycle(1'b1, 4'(c2), 1'b0);
    cycle(1'b1, 4'(d), 1'b0);
    cycle(1'b1, 4'(e), 1'b0);
    cycle(1'b1, 4'(f), 1'b0);
    cycle(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int idle_seen;
    int r;
    logic [3:0] rd;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_minute", int'(minute), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(digit_idx), 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", int'(digit_ready), 1);

    // 12:34:56 back to back
    entry(1, 2, 3, 4, 5, 6);
    chk("e1_minute", int'(minute), 12);
    chk("e1_second", int'(second), 34);
    chk("e1_msecond", int'(msecond), 56);
    chk("e1_load", int'(load), 1);
    chk("e1_busy", int'(busy), 0);
    cycle(1'b0, 4'd0, 1'b0);
    chk("e1_load_drop", int'(load), 0);

    // Maximum and minimum values
    entry(5, 9, 5, 9, 9, 9);
    chk("max_time", {int'(minute), int'(second), int'(msecond)} == {59, 59, 99} ? 1 : 0, 1);
    entry(0, 0, 0, 0, 0, 0);
    chk("zero_time", int'(minute) + int'(second) + int'(msecond), 0);

    // Invalid tens at D0, then 0xA at D3
    cycle(1'b1, 4'd6, 1'b0);
    chk("bad_d0_err", int'(err), 1);
    cycle(1'b1, 4'd1, 1'b0);
    cycle(1'b1, 4'd2, 1'b0);
    cycle(1'b1, 4'd3, 1'b0);
    cycle(1'b1, 4'hA, 1'b0);
    chk("bad_d3_err", int'(err), 1);
    chk("bad_d3_idx", int'(digit_idx), 0);
    cycle(1'b0, 4'd0, 1'b0);
    chk("bad_d3_noload", int'(load), 0);

    // Clear with a digit present, then 00:00:99
    cycle(1'b1, 4'd1, 1'b0);
    cycle(1'b1, 4'd2, 1'b0);
    cycle(1'b1, 4'd3, 1'b0);
    cycle(1'b1, 4'd4, 1'b1);
    chk("clr_err", int'(err), 0);
    chk("clr_idx", int'(digit_idx), 0);
    entry(0, 0, 0, 0, 9, 9);
    chk("clr_msecond", int'(msecond), 99);

    // Clear and a digit during the commit cycle are both ignored
    cycle(1'b1, 4'd2, 1'b0);
    cycle(1'b1, 4'd1, 1'b0);
    cycle(1'b1, 4'd0, 1'b0);
    cycle(1'b1, 4'd7, 1'b0);
    cycle(1'b1, 4'd8, 1'b0);
    cycle(1'b1, 4'd5, 1'b0);
    cycle(1'b1, 4'd3, 1'b1);
    chk("load_under_clear", int'(minute), 21);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
      end else if (r < 20) begin
        cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      end else if (r < 28) begin
        cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      end else begin
        rd = (pos == 0 || pos == 2) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 9));
        cycle(1'b1, rd, 1'b0);
      end
    end
    cycle(1'b0, 4'd0, 1'b1);

    // Reset in the middle of an entry
    entry(1, 2, 3, 4, 5, 6);
    cycle(1'b1, 4'd4, 1'b0);
    cycle(1'b1, 4'd4, 1'b0);
    rst = 1'b1;
    #1;
    pos = 0; exp_min = 0; exp_sec = 0; exp_ms = 0; exp_load = 0; exp_err = 0;
    chk("mid_rst_minute", int'(minute), 0);
    chk("mid_rst_second", int'(second), 0);
    chk("mid_rst_msecond", int'(msecond), 0);
    chk("mid_rst_idx", int'(digit_idx), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 4'd0, 1'b0);

    // Partial entry left idle
    cycle(1'b1, 4'd1, 1'b0);
    cycle(1'b1, 4'd2, 1'b0);
`ifdef DIGIT_TIMEOUT_EN
    idle_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (err) begin
        idle_seen = i + 1;
        break;
      end
    end
    chk("timeout_latency", idle_seen, 16);
    chk("timeout_idx", int'(digit_idx), 0);
    pos = 0;
    cycle(1'b0, 4'd0, 1'b0);
`else
    idle_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (digit_idx != 3'd2 || err) idle_seen++;
    end
    chk("no_timeout_glitches", idle_seen, 0);
    chk("no_timeout_idx", int'(digit_idx), 2);
    cycle(1'b0, 4'd0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
